// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates NUM_REQ execution-unit results onto the common data bus.
// Grants one eligible request per cycle and broadcasts it one cycle later from
// registered outputs. While a branch flush is active, requests whose tags are at or
// after the first squashed ROB tag are consumed and discarded instead of broadcast.
// Default build uses round-robin fairness. Defining CDB_ARB_OLDEST_FIRST_EN selects
// oldest-first (minimum ROB age) arbitration, with ties going to the lowest index.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 32,
  parameter int DATA_W    = 32,
  localparam int PTR_SIZE = $clog2(ROB_DEPTH),
  localparam int SRC_W    = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic [NUM_REQ-1:0]                 req_val,
  input  logic [NUM_REQ-1:0][PTR_SIZE-1:0]   req_robtag,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 req_kill,
  input  logic [PTR_SIZE:0]                  rob_rdptr,
  input  logic                               cdb_flush,
  input  logic [PTR_SIZE-1:0]                cfc_robtag,
  output logic                               cdb_val,
  output logic [PTR_SIZE-1:0]                cdb_robtag,
  output logic [DATA_W-1:0]                  cdb_data,
  output logic [SRC_W-1:0]                   cdb_src
);

  // Ages are distances from the oldest ROB entry; the wrap bit of the read
  // pointer does not matter for modulo-ROB_DEPTH arithmetic.
  logic [PTR_SIZE-1:0]               rd_idx;
  logic [PTR_SIZE-1:0]               age_cfc;
  logic [NUM_REQ-1:0][PTR_SIZE-1:0]  age;
  logic [NUM_REQ-1:0]                squash;
  logic [NUM_REQ-1:0]                kill;
  logic [NUM_REQ-1:0]                elig;
  logic                              gnt_vld;
  logic [SRC_W-1:0]                  gnt_idx;
  logic [NUM_REQ-1:0]                gnt_oh;
  logic [SRC_W-1:0]                  rr_ptr;
  logic                              unused_rdptr_msb;

  logic                              vld_p1;
  logic [PTR_SIZE-1:0]               tag_p1;
  logic [DATA_W-1:0]                 data_p1;
  logic [SRC_W-1:0]                  src_p1;

  assign rd_idx           = rob_rdptr[PTR_SIZE-1:0];
  assign age_cfc          = cfc_robtag - rd_idx;
  assign unused_rdptr_msb = rob_rdptr[PTR_SIZE];

  // Per-request age and flush squash decision.
  always_comb begin
    age    = '0;
    squash = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age[i]    = req_robtag[i] - rd_idx;
      squash[i] = cdb_flush && (age[i] >= age_cfc);
    end
  end

  assign kill = req_val & squash;
  assign elig = req_val & ~squash;

`ifdef CDB_ARB_OLDEST_FIRST_EN
  logic [PTR_SIZE-1:0] best_age;

  // Oldest-first pick: strict less-than keeps the lowest index on ties.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    best_age = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (elig[i] && (!gnt_vld || (age[i] < best_age))) begin
        gnt_vld  = 1'b1;
        gnt_idx  = SRC_W'(i);
        best_age = age[i];
      end
    end
  end

  // Pointer is unused in this build and parks at zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) rr_ptr <= '0;
    else        rr_ptr <= '0;
  end
`else
  logic [SRC_W:0]   scan_sum;
  logic [SRC_W-1:0] scan_idx;

  // Round-robin scan starting at rr_ptr; first eligible request wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (scan_sum >= (SRC_W+1)'(NUM_REQ)) scan_sum = scan_sum - (SRC_W+1)'(NUM_REQ);
      scan_idx = scan_sum[SRC_W-1:0];
      if (!gnt_vld && elig[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // Advance the pointer past the winner only on a real grant; kills never move it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == SRC_W'(NUM_REQ-1)) ? '0 : gnt_idx + SRC_W'(1);
    end
  end
`endif

  // One-hot grant vector; killed requests are consumed in the same cycle.
  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  assign req_ready = kill | gnt_oh;
  assign req_kill  = kill;

  // Stage p1: registered broadcast; payload holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_p1  <= 1'b0;
      tag_p1  <= '0;
      data_p1 <= '0;
      src_p1  <= '0;
    end else begin
      vld_p1 <= gnt_vld;
      if (gnt_vld) begin
        tag_p1  <= req_robtag[gnt_idx];
        data_p1 <= req_data[gnt_idx];
        src_p1  <= gnt_idx;
      end
    end
  end

  assign cdb_val    = vld_p1;
  assign cdb_robtag = tag_p1;
  assign cdb_data   = data_p1;
  assign cdb_src    = src_p1;

endmodule
